// File: rtl/rf_pkg.sv
// Shared constants and the write/issue index decoder for the 2-read/1-write
// register file with busy scoreboard.
package rf_pkg;

    localparam int RF_DATA_W     = 16;
    localparam int RF_ADDR_W     = 3;

    // The decoder is sized for the widest supported index; callers zero-extend
    // their index and keep only the low 2**ADDR_W bits of the result.
    localparam int RF_MAX_ADDR_W = 8;
    localparam int RF_MAX_NREGS  = 2 ** RF_MAX_ADDR_W;

    // Binary index to one-hot select vector.
    function automatic logic [RF_MAX_NREGS-1:0] onehot_dec(input logic [RF_MAX_ADDR_W-1:0] idx);
        logic [RF_MAX_NREGS-1:0] dec;
        dec      = '0;
        dec[idx] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: binary-index mux over the register array plus
// the busy lookup, with optional same-cycle forwarding of the write port.
module rf_read_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic [(DATA_W << ADDR_W)-1:0] regs_flat,
    input  logic [(1 << ADDR_W)-1:0]      busy_vec,
    input  logic [ADDR_W-1:0]             readnum,
    input  logic                          write,
    input  logic [ADDR_W-1:0]             writenum,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          issue,
    input  logic [ADDR_W-1:0]             issuenum,
    output logic [DATA_W-1:0]             data_out,
    output logic                          busy
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              hit;
    logic              new_producer;

    // Unpack the flattened register bus so the read can be a plain index.
    for (genvar g = 0; g < NREGS; g++) begin : g_unpack
        assign regs[g] = regs_flat[g*DATA_W +: DATA_W];
    end

    // Read mux with write forwarding; a forwarded register is only reported
    // free when the same edge does not also hand it to a new producer.
    always_comb begin
        hit          = (BYPASS != 0) && write && (writenum == readnum);
        new_producer = issue && (issuenum == writenum);
        data_out     = hit ? data_in : regs[readnum];
        busy         = busy_vec[readnum] & ~(hit & ~new_producer);
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register bank with one write port, two independent read ports (ALU operand
// A and B) and a per-register busy scoreboard for results still in flight.
module regfile_2r1w_sb
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        writenum,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [ADDR_W-1:0]        readnum_a,
    input  logic [ADDR_W-1:0]        readnum_b,
    output logic [DATA_W-1:0]        data_out_a,
    output logic [DATA_W-1:0]        data_out_b,
    input  logic                     issue,
    input  logic [ADDR_W-1:0]        issuenum,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [(1 << ADDR_W)-1:0] busy_vec
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0]        regs_q [NREGS];
    logic [DATA_W-1:0]        regs_d [NREGS];
    logic [NREGS-1:0]         busy_q;
    logic [NREGS-1:0]         busy_d;

    logic [RF_MAX_NREGS-1:0]  wr_dec_full;
    logic [RF_MAX_NREGS-1:0]  is_dec_full;
    logic [NREGS-1:0]         wr_dec;
    logic [NREGS-1:0]         is_dec;
    logic [NREGS-1:0]         load;
    logic [NREGS*DATA_W-1:0]  regs_flat;

    assign wr_dec_full = onehot_dec(RF_MAX_ADDR_W'(writenum));
    assign is_dec_full = onehot_dec(RF_MAX_ADDR_W'(issuenum));
    assign wr_dec      = wr_dec_full[NREGS-1:0];
    assign is_dec      = is_dec_full[NREGS-1:0];
    assign load        = {NREGS{write}} & wr_dec;

    // Decoder bits above the implemented register count are never used.
    if (NREGS < RF_MAX_NREGS) begin : g_dec_tail
        logic unused_dec_tail;
        assign unused_dec_tail = ^{wr_dec_full[RF_MAX_NREGS-1:NREGS],
                                   is_dec_full[RF_MAX_NREGS-1:NREGS]};
    end

    // Next register contents: only the selected register loads data_in.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = load[i] ? data_in : regs_q[i];
        end
    end

    // Next scoreboard: write retires a producer, issue starts one; issue is
    // applied last so a same-index collision leaves the register busy.
    always_comb begin
        busy_d = (busy_q & ~load) | ({NREGS{issue}} & is_dec);
    end

    // Register array and scoreboard state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign busy_vec = busy_q;

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_a (
        .regs_flat (regs_flat),
        .busy_vec  (busy_q),
        .readnum   (readnum_a),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .issue     (issue),
        .issuenum  (issuenum),
        .data_out  (data_out_a),
        .busy      (busy_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_b (
        .regs_flat (regs_flat),
        .busy_vec  (busy_q),
        .readnum   (readnum_b),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .issue     (issue),
        .issuenum  (issuenum),
        .data_out  (data_out_b),
        .busy      (busy_b)
    );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: directed scenarios plus a randomized run checked
// against an array-based model of the register bank and scoreboard.
module tb_regfile_2r1w_sb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;
    localparam int BYPASS = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              write;
    logic [ADDR_W-1:0] writenum;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] readnum_a;
    logic [ADDR_W-1:0] readnum_b;
    logic [DATA_W-1:0] data_out_a;
    logic [DATA_W-1:0] data_out_b;
    logic              issue;
    logic [ADDR_W-1:0] issuenum;
    logic              busy_a;
    logic              busy_b;
    logic [NREGS-1:0]  busy_vec;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_reg [NREGS];
    logic [NREGS-1:0]  m_busy;

    regfile_2r1w_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .writenum   (writenum),
        .data_in    (data_in),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .issue      (issue),
        .issuenum   (issuenum),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] rn);
        if (BYPASS != 0 && write && writenum == rn) return data_in;
        return m_reg[rn];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] rn);
        if (BYPASS != 0 && write && writenum == rn && !(issue && issuenum == writenum)) return 1'b0;
        return m_busy[rn];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        m_busy = '0;
    endtask

    // Apply the current inputs to the model, then advance past the next edge.
    task automatic clk_edge();
        if (write) begin
            m_reg[writenum]  = data_in;
            m_busy[writenum] = 1'b0;
        end
        if (issue) m_busy[issuenum] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0;
        issue = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 4; i++) begin
            write    = 1'b1;
            writenum = ADDR_W'(2 * i + 1);
            data_in  = DATA_W'($urandom_range(1, 16'hFFFF));
            issue    = 1'b1;
            issuenum = ADDR_W'(i);
            clk_edge();
        end
        idle();
        readnum_a = 3'd1;
        readnum_b = 3'd0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_assert++;
        if (data_out_a !== 16'h0) begin n_fail++; $display("FAIL reset_async_a: got %h expected 0000", data_out_a); end
        n_assert++;
        if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset_async_busy_vec: got %h expected 00", busy_vec); end
        n_assert++;
        if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_async_busy_b: got %b expected 0", busy_b); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            readnum_a = ADDR_W'(i);
            readnum_b = ADDR_W'(NREGS - 1 - i);
            #1;
            n_assert++;
            if (data_out_a !== 16'h0 || data_out_b !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_read_r%0d: got a=%h b=%h expected 0000", i, data_out_a, data_out_b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        write    = 1'b1;
        writenum = 3'd3;
        data_in  = 16'h1234;
        clk_edge();
        writenum = 3'd7;
        data_in  = 16'hBEEF;
        clk_edge();
        idle();
        readnum_a = 3'd3;
        readnum_b = 3'd7;
        #1;
        n_assert++;
        if (data_out_a !== 16'h1234) begin n_fail++; $display("FAIL write_read_r3: got %h expected 1234", data_out_a); end
        n_assert++;
        if (data_out_b !== 16'hBEEF) begin n_fail++; $display("FAIL write_read_r7: got %h expected beef", data_out_b); end
        for (int i = 0; i < NREGS; i++) begin
            if (i != 3 && i != 7) begin
                readnum_a = ADDR_W'(i);
                #1;
                n_assert++;
                if (data_out_a !== 16'h0) begin n_fail++; $display("FAIL write_untouched_r%0d: got %h expected 0000", i, data_out_a); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        write    = 1'b1;
        writenum = 3'd5;
        data_in  = 16'h0001;
        clk_edge();
        data_in   = 16'hA5A5;
        readnum_a = 3'd5;
        readnum_b = 3'd5;
        #3;
        n_assert++;
        if (data_out_a !== ((BYPASS != 0) ? 16'hA5A5 : 16'h0001)) begin n_fail++; $display("FAIL bypass_before_a: got %h", data_out_a); end
        n_assert++;
        if (data_out_b !== ((BYPASS != 0) ? 16'hA5A5 : 16'h0001)) begin n_fail++; $display("FAIL bypass_before_b: got %h", data_out_b); end
        clk_edge();
        idle();
        #1;
        n_assert++;
        if (data_out_a !== 16'hA5A5 || data_out_b !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL bypass_after: got a=%h b=%h expected a5a5", data_out_a, data_out_b);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        issue     = 1'b1;
        issuenum  = 3'd2;
        readnum_a = 3'd2;
        #3;
        n_assert++;
        if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL sb_before_issue: got %h expected 00", busy_vec); end
        clk_edge();
        idle();
        #1;
        n_assert++;
        if (busy_vec !== 8'h04) begin n_fail++; $display("FAIL sb_issue_vec: got %h expected 04", busy_vec); end
        n_assert++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL sb_issue_busy_a: got %b expected 1", busy_a); end
        write    = 1'b1;
        writenum = 3'd2;
        data_in  = 16'h0F0F;
        #1;
        n_assert++;
        if (busy_a !== ((BYPASS != 0) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL sb_write_busy_a: got %b", busy_a); end
        n_assert++;
        if (busy_vec !== 8'h04) begin n_fail++; $display("FAIL sb_write_vec_raw: got %h expected 04", busy_vec); end
        clk_edge();
        idle();
        #1;
        n_assert++;
        if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL sb_cleared: got %h expected 00", busy_vec); end
        n_assert++;
        if (data_out_a !== 16'h0F0F) begin n_fail++; $display("FAIL sb_data_r2: got %h expected 0f0f", data_out_a); end
    endtask

    task automatic test_collision();
        idle();
        issue    = 1'b1;
        issuenum = 3'd4;
        clk_edge();
        write     = 1'b1;
        writenum  = 3'd4;
        data_in   = 16'h7777;
        readnum_a = 3'd4;
        #1;
        n_assert++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL collide_busy_a: got %b expected 1", busy_a); end
        clk_edge();
        idle();
        #1;
        n_assert++;
        if (busy_vec !== 8'h10) begin n_fail++; $display("FAIL collide_vec: got %h expected 10", busy_vec); end
        n_assert++;
        if (data_out_a !== 16'h7777) begin n_fail++; $display("FAIL collide_data: got %h expected 7777", data_out_a); end
        write = 1'b1;
        clk_edge();
        idle();
    endtask

    task automatic test_dual_reset();
        idle();
        issue    = 1'b1;
        issuenum = 3'd1;
        write    = 1'b1;
        writenum = 3'd6;
        data_in  = 16'h6666;
        clk_edge();
        idle();
        readnum_a = 3'd6;
        #1;
        n_assert++;
        if (busy_vec !== 8'h02) begin n_fail++; $display("FAIL dual_vec: got %h expected 02", busy_vec); end
        n_assert++;
        if (data_out_a !== 16'h6666) begin n_fail++; $display("FAIL dual_data_r6: got %h expected 6666", data_out_a); end
        write    = 1'b1;
        writenum = 3'd6;
        data_in  = 16'h9999;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle();
        model_reset();
        #1;
        n_assert++;
        if (data_out_a !== 16'h0) begin n_fail++; $display("FAIL reset_drops_write: got %h expected 0000", data_out_a); end
        n_assert++;
        if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset_clears_busy: got %h expected 00", busy_vec); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if (data_out_a !== 16'h0) begin n_fail++; $display("FAIL reset_release_r6: got %h expected 0000", data_out_a); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            write     = 1'($urandom_range(0, 1));
            writenum  = ADDR_W'($urandom_range(0, NREGS - 1));
            data_in   = DATA_W'($urandom);
            issue     = 1'($urandom_range(0, 1));
            issuenum  = ADDR_W'($urandom_range(0, NREGS - 1));
            readnum_a = ADDR_W'($urandom_range(0, NREGS - 1));
            readnum_b = ADDR_W'($urandom_range(0, NREGS - 1));
            #1;
            n_assert++;
            if (data_out_a !== exp_data(readnum_a)) begin n_fail++; $display("FAIL rand_data_a c%0d: got %h expected %h", c, data_out_a, exp_data(readnum_a)); end
            n_assert++;
            if (data_out_b !== exp_data(readnum_b)) begin n_fail++; $display("FAIL rand_data_b c%0d: got %h expected %h", c, data_out_b, exp_data(readnum_b)); end
            n_assert++;
            if (busy_a !== exp_busy(readnum_a)) begin n_fail++; $display("FAIL rand_busy_a c%0d: got %b expected %b", c, busy_a, exp_busy(readnum_a)); end
            n_assert++;
            if (busy_b !== exp_busy(readnum_b)) begin n_fail++; $display("FAIL rand_busy_b c%0d: got %b expected %b", c, busy_b, exp_busy(readnum_b)); end
            n_assert++;
            if (busy_vec !== m_busy) begin n_fail++; $display("FAIL rand_busy_vec c%0d: got %h expected %h", c, busy_vec, m_busy); end
            clk_edge();
        end
        idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        write     = 1'b0;
        writenum  = '0;
        data_in   = '0;
        issue     = 1'b0;
        issuenum  = '0;
        readnum_a = '0;
        readnum_b = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_dual_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
